// File: rtl/scanner_pkg.sv
// Shared encodings for the scanner node: FSM states, peer comm codes and 7-segment glyphs.
// The optional display (SCANNER_HEX_EN) uses the glyph constants and seg_digit().
package scanner_pkg;

  typedef enum logic [2:0] {
    ST_LOWPOWER     = 3'd0,
    ST_STANDBY      = 3'd1,
    ST_COLLECTING   = 3'd2,
    ST_IDLE         = 3'd3,
    ST_TRANSFERRING = 3'd4,
    ST_FLUSHING     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COMM_INACTIVE      = 2'b00,
    COMM_GO_TO_STANDBY = 2'b01,
    COMM_START_SCAN    = 2'b10,
    COMM_START_FLUSH   = 2'b11
  } comm_t;

  // Active-low glyphs. State glyphs carry segment a in the MSB; digit glyphs carry segment g in the MSB.
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;
  localparam logic [6:0] SEG_ST_L    = 7'b1110001;
  localparam logic [6:0] SEG_ST_S    = 7'b0100100;
  localparam logic [6:0] SEG_ST_C    = 7'b0110001;
  localparam logic [6:0] SEG_ST_D    = 7'b1000010;
  localparam logic [6:0] SEG_ST_T    = 7'b1110000;
  localparam logic [6:0] SEG_ST_F    = 7'b0111000;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/scanner_hex_display.sv
// Combinational 7-segment decode of the node state and fill level.
// Only instantiated when SCANNER_HEX_EN is defined.
module scanner_hex_display
  import scanner_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [2:0]    state,
  input  logic [CW-1:0] fill,
  output logic [6:0]    state_hex,
  output logic [6:0]    fill_hex
);

  // Glyph selection for state and fill digit
  always_comb begin
    state_hex = SEG_BLANK;
    fill_hex  = SEG_DASH;
    case (state)
      ST_LOWPOWER:     state_hex = SEG_ST_L;
      ST_STANDBY:      state_hex = SEG_ST_S;
      ST_COLLECTING:   state_hex = SEG_ST_C;
      ST_IDLE:         state_hex = SEG_ST_D;
      ST_TRANSFERRING: state_hex = SEG_ST_T;
      ST_FLUSHING:     state_hex = SEG_ST_F;
      default:         state_hex = SEG_BLANK;
    endcase
    if (int'(fill) > 32'sd9) begin
      fill_hex = SEG_DASH;
    end else begin
      fill_hex = seg_digit(4'(fill));
    end
  end

endmodule

// File: rtl/scanner_node.sv
// Scanner node: sample buffer, peer comm link, valid/ready drain and timed flush.
// Optional SCANNER_HEX_EN adds state_hex/fill_hex 7-segment outputs.
module scanner_node
  import scanner_pkg::*;
#(
  parameter int ID           = 0,
  parameter int DEPTH        = 10,
  parameter int DATA_W       = 8,
  parameter int FLUSH_AT     = 6,
  parameter int STANDBY_LEAD = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        user_cmd,
  input  logic [1:0]        rx_comm,
  output logic [1:0]        tx_comm,
  input  logic              scan_valid,
  input  logic [DATA_W-1:0] scan_data,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [DATA_W-1:0] xfer_data,
  output logic [2:0]        state,
  output logic [CW-1:0]     fill
`ifdef SCANNER_HEX_EN
 ,output logic [6:0]        state_hex
 ,output logic [6:0]        fill_hex
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CW-1:0] LVL_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] LVL_SCAN  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LVL_STBY  = CW'(DEPTH - STANDBY_LEAD);
  localparam logic [CW-1:0] LVL_FLUSH = CW'(FLUSH_AT);
  localparam logic [CW-1:0] LVL_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(FLUSH_CYCLES - 1);

  if (DEPTH < 4 || FLUSH_AT < 1 || FLUSH_AT >= DEPTH - 2 || STANDBY_LEAD < 2 ||
      STANDBY_LEAD >= DEPTH - FLUSH_AT || FLUSH_CYCLES < 1 || ID < 0) begin : g_param_check
    $error("scanner_node: illegal parameter combination");
  end

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       fill_r;
  logic [TW-1:0]       timer_r;
  logic                do_write_s, do_pop_s, clear_s, timer_inc_s, xfer_valid_s;
  comm_t               tx_comm_s;

  // Explicit wrap so non-power-of-2 depths never index past the last word
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Present-state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LOWPOWER;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus datapath strobes and comb outputs
  always_comb begin
    state_next_s = state_r;
    do_write_s   = 1'b0;
    do_pop_s     = 1'b0;
    clear_s      = 1'b0;
    timer_inc_s  = 1'b0;
    xfer_valid_s = 1'b0;
    tx_comm_s    = COMM_INACTIVE;
    case (state_r)
      ST_LOWPOWER: begin
        if (rx_comm == COMM_GO_TO_STANDBY || user_cmd[0]) state_next_s = ST_STANDBY;
        else                                              state_next_s = ST_LOWPOWER;
      end
      ST_STANDBY: begin
        if (rx_comm == COMM_START_SCAN || user_cmd[2]) begin
          clear_s      = 1'b1;
          state_next_s = ST_COLLECTING;
        end else begin
          state_next_s = ST_STANDBY;
        end
      end
      ST_COLLECTING: begin
        if (fill_r == LVL_SCAN)       tx_comm_s = COMM_START_SCAN;
        else if (fill_r == LVL_STBY)  tx_comm_s = COMM_GO_TO_STANDBY;
        else if (fill_r == LVL_FLUSH) tx_comm_s = COMM_START_FLUSH;
        else                          tx_comm_s = COMM_INACTIVE;
        if (scan_valid && fill_r != LVL_FULL) begin
          do_write_s = 1'b1;
          if (fill_r == LVL_SCAN) state_next_s = ST_IDLE;
          else                    state_next_s = ST_COLLECTING;
        end else begin
          state_next_s = ST_COLLECTING;
        end
      end
      ST_IDLE: begin
        if (user_cmd[1])                        state_next_s = ST_TRANSFERRING;
        else if (rx_comm == COMM_START_FLUSH)   state_next_s = ST_FLUSHING;
        else                                    state_next_s = ST_IDLE;
      end
      ST_TRANSFERRING: begin
        xfer_valid_s = (fill_r != {CW{1'b0}});
        if (xfer_valid_s && xfer_ready) begin
          do_pop_s = 1'b1;
          if (fill_r == LVL_ONE) state_next_s = ST_LOWPOWER;
          else                   state_next_s = ST_TRANSFERRING;
        end else begin
          state_next_s = ST_TRANSFERRING;
        end
      end
      ST_FLUSHING: begin
        if (timer_r == TMR_LAST) begin
          clear_s      = 1'b1;
          state_next_s = ST_LOWPOWER;
        end else begin
          timer_inc_s  = 1'b1;
          state_next_s = ST_FLUSHING;
        end
      end
      default: state_next_s = ST_LOWPOWER;
    endcase
  end

  // Pointers, fill level and flush timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      fill_r   <= {CW{1'b0}};
      timer_r  <= {TW{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      fill_r   <= {CW{1'b0}};
      timer_r  <= {TW{1'b0}};
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
        fill_r   <= fill_r + LVL_ONE;
      end else if (do_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
        fill_r   <= fill_r - LVL_ONE;
      end else begin
        fill_r   <= fill_r;
      end
      if (timer_inc_s) timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      else             timer_r <= timer_r;
    end
  end

  // Sample storage, cleared on reset so xfer_data is never X
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else if (do_write_s) begin
      mem_r[wr_ptr_r] <= scan_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign state      = state_r;
  assign fill       = fill_r;
  assign tx_comm    = tx_comm_s;
  assign xfer_valid = xfer_valid_s;
  assign xfer_data  = mem_r[rd_ptr_r];

`ifdef SCANNER_HEX_EN
  scanner_hex_display #(.CW(CW)) u_hex (
    .state     (state_r),
    .fill      (fill_r),
    .state_hex (state_hex),
    .fill_hex  (fill_hex)
  );
`endif

endmodule
